// File: rtl/ctrl_pkg.sv
// Shared control types for the stage-4 branch resolver: word type, transfer kind,
// resolver state and the compare-flag bit indices produced by stage 3.
package ctrl_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        K_NONE = 2'b00,
        K_BR   = 2'b01,
        K_JAL  = 2'b10,
        K_JALR = 2'b11
    } kind_t;

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_REDIRECT = 2'b01,
        S_FLUSH    = 2'b10
    } state_t;

    // Bit positions inside the stage-3 compare flag vector.
    localparam logic [1:0] COND_EQ = 2'd0;
    localparam logic [1:0] COND_NE = 2'd1;
    localparam logic [1:0] COND_LT = 2'd2;
    localparam logic [1:0] COND_GE = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Stage-4 branch/JAL/JALR resolver: static not-taken, redirect handshake to fetch,
// fixed-depth flush of wrong-path stages, link value and branch statistics.
module branch_resolver
    import ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [1:0]       kind,
    input  logic [1:0]       cond,
    input  logic [3:0]       compare,
    input  logic [XLEN-1:0]  eval,
    input  logic [XLEN-1:0]  pc,
    input  logic [XLEN-1:0]  imm,
    input  logic             fetch_ready,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             flush,
    output logic             link_valid,
    output logic [XLEN-1:0]  link_value,
    output logic             busy,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam int FC_W = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1);
    localparam logic [FC_W-1:0] FC_INIT  = FC_W'(FLUSH_DEPTH);
    localparam logic [XLEN-1:0] JALR_MSK = {{(XLEN-1){1'b1}}, 1'b0};

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              rv_q, rv_d;
    logic [XLEN-1:0]   rpc_q, rpc_d;
    logic              flush_q, flush_d;
    logic              lv_q, lv_d;
    logic [XLEN-1:0]   lval_q, lval_d;

    kind_t             k;
    logic              taken;
    logic              accept;
    logic [XLEN-1:0]   target;

    assign k = kind_t'(kind);

    always_comb begin
        taken  = ((k == K_BR) && compare[cond]) || (k == K_JAL) || (k == K_JALR);
        accept = valid_in && (k != K_NONE) && (state_q == S_IDLE);
        target = (k == K_JALR) ? (eval & JALR_MSK) : (pc + imm);
    end

    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        rv_d    = rv_q;
        rpc_d   = rpc_q;
        flush_d = flush_q;
        lv_d    = 1'b0;
        lval_d  = lval_q;
        case (state_q)
            S_IDLE: begin
                if (accept && taken) begin
                    state_d = S_REDIRECT;
                    rpc_d   = target;
                    rv_d    = 1'b1;
                    flush_d = 1'b1;
                end
                if (accept && ((k == K_JAL) || (k == K_JALR))) begin
                    lv_d   = 1'b1;
                    lval_d = pc + XLEN'(4);
                end
            end
            S_REDIRECT: begin
                // Target and valid hold until fetch takes it; flush continues into S_FLUSH.
                if (fetch_ready) begin
                    rv_d = 1'b0;
                    if (FLUSH_DEPTH == 0) begin
                        state_d = S_IDLE;
                        flush_d = 1'b0;
                    end else begin
                        state_d = S_FLUSH;
                        fcnt_d  = FC_INIT;
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q <= FC_W'(1)) begin
                    state_d = S_IDLE;
                    flush_d = 1'b0;
                    fcnt_d  = '0;
                end else begin
                    fcnt_d = fcnt_q - FC_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                rv_d    = 1'b0;
                flush_d = 1'b0;
                fcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            flush_q <= 1'b0;
            lv_q    <= 1'b0;
            lval_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            flush_q <= flush_d;
            lv_q    <= lv_d;
            lval_q  <= lval_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (accept && (k == K_BR)),
        .count (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (accept && taken),
        .count (taken_count)
    );

    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign flush          = flush_q;
    assign link_valid     = lv_q;
    assign link_value     = lval_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: a default instance plus a 4-bit-counter instance
// sharing the same stimulus.
module tb_branch_resolver;
    import ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        valid_in;
    logic [1:0]  kind;
    logic [1:0]  cond;
    logic [3:0]  compare;
    logic [31:0] eval;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        fetch_ready;

    logic        a_rv, a_flush, a_lv, a_busy;
    logic [31:0] a_rpc, a_lval, a_br, a_tk;
    logic        b_rv, b_flush, b_lv, b_busy;
    logic [31:0] b_rpc, b_lval;
    logic [3:0]  b_br, b_tk;

    int n_checks = 0;
    int n_fail   = 0;

    branch_resolver #(.XLEN(32), .FLUSH_DEPTH(3), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset), .valid_in(valid_in), .kind(kind), .cond(cond),
        .compare(compare), .eval(eval), .pc(pc), .imm(imm), .fetch_ready(fetch_ready),
        .redirect_valid(a_rv), .redirect_pc(a_rpc), .flush(a_flush), .link_valid(a_lv),
        .link_value(a_lval), .busy(a_busy), .branch_count(a_br), .taken_count(a_tk)
    );

    branch_resolver #(.XLEN(32), .FLUSH_DEPTH(3), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .valid_in(valid_in), .kind(kind), .cond(cond),
        .compare(compare), .eval(eval), .pc(pc), .imm(imm), .fetch_ready(fetch_ready),
        .redirect_valid(b_rv), .redirect_pc(b_rpc), .flush(b_flush), .link_valid(b_lv),
        .link_value(b_lval), .busy(b_busy), .branch_count(b_br), .taken_count(b_tk)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic [1:0] k, input logic [1:0] c, input logic [3:0] cmp,
                          input logic [31:0] e, input logic [31:0] p, input logic [31:0] i);
        kind    = k;
        cond    = c;
        compare = cmp;
        eval    = e;
        pc      = p;
        imm     = i;
    endtask

    task automatic issue(input logic [1:0] k, input logic [1:0] c, input logic [3:0] cmp,
                         input logic [31:0] e, input logic [31:0] p, input logic [31:0] i);
        set_in(k, c, cmp, e, p, i);
        valid_in = 1'b1;
        step();
        valid_in = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (a_busy && n < 20) begin
            step();
            n++;
        end
        check(tag, a_busy, 1'b0);
    endtask

    initial begin
        int fl;
        reset       = 1'b1;
        valid_in    = 1'b0;
        fetch_ready = 1'b1;
        set_in(2'b00, 2'b00, 4'h0, 32'h0, 32'h0, 32'h0);
        step();
        step();
        check("rst_rv", a_rv, 1'b0);
        check("rst_flush", a_flush, 1'b0);
        check("rst_busy", a_busy, 1'b0);
        check("rst_cnt", {a_br, a_tk}, 64'h0);
        reset = 1'b0;
        step();

        // 1: beq taken
        issue(2'b01, COND_EQ, 4'b0001, 32'h0, 32'h100, 32'h20);
        check("t1_rv", a_rv, 1'b1);
        check("t1_rpc", a_rpc, 32'h120);
        check("t1_lv", a_lv, 1'b0);
        check("t1_br", a_br, 32'd1);
        check("t1_tk", a_tk, 32'd1);
        fl = a_flush ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) check("t1_rv_drop", a_rv, 1'b0);
            if (a_flush) fl++;
        end
        check("t1_flush_len", fl, 4);
        check("t1_idle", a_busy, 1'b0);

        // 2: bne not taken
        issue(2'b01, COND_NE, 4'b0001, 32'h0, 32'h180, 32'h40);
        check("t2_rv", a_rv, 1'b0);
        check("t2_flush", a_flush, 1'b0);
        check("t2_busy", a_busy, 1'b0);
        check("t2_br", a_br, 32'd2);
        check("t2_tk", a_tk, 32'd1);

        // 3: jalr
        issue(2'b11, COND_EQ, 4'h0, 32'h2003, 32'h40, 32'h999);
        check("t3_rpc", a_rpc, 32'h2002);
        check("t3_lv", a_lv, 1'b1);
        check("t3_lval", a_lval, 32'h44);
        step();
        check("t3_lv_pulse", a_lv, 1'b0);
        check("t3_lval_hold", a_lval, 32'h44);
        wait_idle("t3_idle");
        check("t3_tk", a_tk, 32'd2);

        // 4: jal with fetch stall, wrong-path branches held valid throughout
        fetch_ready = 1'b0;
        issue(2'b10, COND_EQ, 4'h0, 32'h0, 32'h200, 32'h80);
        check("t4_rpc", a_rpc, 32'h280);
        check("t4_lval", a_lval, 32'h204);
        set_in(2'b01, COND_EQ, 4'b0001, 32'h0, 32'h900, 32'h4);
        valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_stall_rv", a_rv, 1'b1);
            check("t4_stall_rpc", a_rpc, 32'h280);
            check("t4_stall_flush", a_flush, 1'b1);
        end
        fetch_ready = 1'b1;
        step();
        check("t4_hs_rv", a_rv, 1'b0);
        check("t4_hs_flush", a_flush, 1'b1);
        step();
        step();
        check("t4_fl_flush", a_flush, 1'b1);
        step();
        valid_in = 1'b0;
        check("t4_idle", a_busy, 1'b0);
        check("t4_br", a_br, 32'd2);
        check("t4_tk", a_tk, 32'd3);

        // 5: asynchronous reset mid-FLUSH
        issue(2'b01, COND_EQ, 4'b0001, 32'h0, 32'h300, 32'h10);
        step();
        check("t5_in_flush", {a_busy, a_rv, a_flush}, 3'b101);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_flags", {a_busy, a_rv, a_flush, a_lv}, 4'b0000);
        check("t5_rst_rpc", a_rpc, 32'h0);
        check("t5_rst_lval", a_lval, 32'h0);
        check("t5_rst_cnt", {a_br, a_tk}, 64'h0);
        #1 reset = 1'b0;
        step();
        issue(2'b01, COND_LT, 4'b0100, 32'h0, 32'h400, 32'hFFFF_FFFC);
        check("t5_rv", a_rv, 1'b1);
        check("t5_rpc", a_rpc, 32'h3FC);
        check("t5_cnt", {a_br, a_tk}, {32'd1, 32'd1});
        wait_idle("t5_idle");

        // 6: counter saturation on 4-bit instance, then wrapping target
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_in(2'b01, COND_LT, 4'b1011, 32'h0, 32'h500, 32'h8);
        valid_in = 1'b1;
        repeat (20) step();
        check("t6_b_br", b_br, 4'd15);
        check("t6_b_tk", b_tk, 4'd0);
        check("t6_a_br", a_br, 32'd20);
        check("t6_busy", b_busy, 1'b0);
        set_in(2'b01, COND_GE, 4'b1000, 32'h0, 32'hFFFF_FFF0, 32'h20);
        step();
        valid_in = 1'b0;
        check("t6_a_rpc", a_rpc, 32'h10);
        check("t6_b_rpc", b_rpc, 32'h10);
        check("t6_b_br_sat", b_br, 4'd15);
        check("t6_b_tk", b_tk, 4'd1);
        check("t6_a_br21", a_br, 32'd21);
        wait_idle("t6_idle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
